// File: rtl/i2c_codec_reg_target.sv
// I2C write-only register target for the WM8731 configuration protocol:
// address byte + two data bytes -> {reg_addr[6:0], reg_data[8:0]} write strobe.
module i2c_codec_reg_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'b0011010,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       wr_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_BYTE1     = 4'd3,
    S_ACK1      = 4'd4,
    S_BYTE2     = 4'd5,
    S_ACK2      = 4'd6,
    S_WAIT_STOP = 4'd7,
    S_IGNORE    = 4'd8
  } state_t;

  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  // Line index 0 = SCL, 1 = SDA
  logic [1:0] w_line_in;
  logic [1:0] r_meta, r_sync, r_filt, r_filt_d;
  logic [3:0] r_flt_cnt [2];

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte1;
  logic       r_sda_oe;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic       r_wr_valid, r_busy, r_err;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_shift_en, w_byte_done, w_ack_state, w_in_txn;
  logic [7:0] w_byte;
  logic       w_sda_oe_nxt, w_wr_valid_nxt, w_err_nxt;

  assign w_line_in = {sda, scl};

  // Synchronizer and glitch filter; idle-high reset keeps release from looking like START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta       <= 2'b11;
      r_sync       <= 2'b11;
      r_filt       <= 2'b11;
      r_filt_d     <= 2'b11;
      r_flt_cnt[0] <= 4'd0;
      r_flt_cnt[1] <= 4'd0;
    end else begin
      r_meta   <= w_line_in;
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] != r_filt[i]) begin
          if (r_flt_cnt[i] == FLT_LAST) begin
            r_filt[i]    <= r_sync[i];
            r_flt_cnt[i] <= 4'd0;
          end else begin
            r_flt_cnt[i] <= r_flt_cnt[i] + 4'd1;
          end
        end else begin
          r_flt_cnt[i] <= 4'd0;
        end
      end
    end
  end

  assign w_scl_rise  = r_filt[0] & ~r_filt_d[0];
  assign w_scl_fall  = ~r_filt[0] & r_filt_d[0];
  assign w_start     = r_filt[0] & r_filt_d[0] & r_filt_d[1] & ~r_filt[1];
  assign w_stop      = r_filt[0] & r_filt_d[0] & ~r_filt_d[1] & r_filt[1];
  assign w_byte      = {r_shift[6:0], r_filt[1]};
  assign w_shift_en  = w_scl_rise & ((r_state == S_ADDR) | (r_state == S_BYTE1) |
                                     (r_state == S_BYTE2) | (r_state == S_WAIT_STOP));
  assign w_byte_done = w_shift_en & (r_bit_cnt == 3'd7);
  assign w_ack_state = (r_state == S_ADDR_ACK) | (r_state == S_ACK1) | (r_state == S_ACK2);
  assign w_in_txn    = w_ack_state | (r_state == S_BYTE1) | (r_state == S_BYTE2);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; START/STOP override every state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      w_state_nxt = S_IDLE;
        S_ADDR: begin
          if (w_byte_done) begin
            w_state_nxt = (w_byte == {DEVICE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR_ACK:  w_state_nxt = (w_scl_fall && r_sda_oe) ? S_BYTE1 : S_ADDR_ACK;
        S_BYTE1:     w_state_nxt = w_byte_done ? S_ACK1 : S_BYTE1;
        S_ACK1:      w_state_nxt = (w_scl_fall && r_sda_oe) ? S_BYTE2 : S_ACK1;
        S_BYTE2:     w_state_nxt = w_byte_done ? S_ACK2 : S_BYTE2;
        S_ACK2:      w_state_nxt = (w_scl_fall && r_sda_oe) ? S_WAIT_STOP : S_ACK2;
        S_WAIT_STOP: w_state_nxt = S_WAIT_STOP;
        S_IGNORE:    w_state_nxt = S_IGNORE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: ACK drive toggles on SCL falls inside an ACK state (on, then off).
  always_comb begin
    w_sda_oe_nxt   = 1'b0;
    w_wr_valid_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    if (w_start || w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_err_nxt    = w_in_txn;
    end else if (w_ack_state) begin
      if (w_scl_fall) begin
        w_sda_oe_nxt   = ~r_sda_oe;
        w_wr_valid_nxt = r_sda_oe & (r_state == S_ACK2);
      end else begin
        w_sda_oe_nxt = r_sda_oe;
      end
    end else begin
      w_sda_oe_nxt = 1'b0;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_addr  <= 7'd0;
      r_wr_data  <= 9'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_byte1    <= 8'd0;
    end else begin
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_start) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_byte_done && (r_state == S_BYTE1)) begin
        r_byte1 <= w_byte;
      end
      if (w_wr_valid_nxt) begin
        r_wr_addr <= r_byte1[7:1];
        r_wr_data <= {r_byte1[0], r_shift};
      end
    end
  end

  // Open-drain: release combinationally as soon as START/STOP is seen.
  assign sda      = (r_sda_oe && !w_start && !w_stop) ? 1'b0 : 1'bz;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_valid = r_wr_valid;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
